stream_checker: RTL and testbench

// - Downstream consumer of a corecomplex output port. Accepts values over the core

---
 rtl/tis_pkg.sv | 19 +
 rtl/stream_checker.sv | 114 +++++++++++
 tb/tb_stream_checker.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tis_pkg.sv
// Shared TIS value type, legal value range and the checker FSM encoding.
package tis_pkg;

    typedef logic signed [10:0] tis_val_t;

    localparam int TIS_MAX = 999;
    localparam int TIS_MIN = -999;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    function automatic logic in_range(input tis_val_t v);
        return (int'(v) <= TIS_MAX) && (int'(v) >= TIS_MIN);
    endfunction

endpackage

// File: rtl/stream_checker.sv
// Consumes values from a core output port over the rready/read handshake and
// scores each one against an expected-value list.
module stream_checker
    import tis_pkg::*;
#(
    parameter int DW    = 11,
    parameter int DEPTH = 39,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [AW-1:0]        exp_len,
    input  logic signed [DW-1:0] expected [DEPTH],
    input  logic                 rready,
    input  logic signed [DW-1:0] in,
    output logic                 read,
    output logic [7:0]           count,
    output logic [7:0]           correct,
    output logic signed [DW-1:0] last_value,
    output logic                 done,
    output logic                 err,
    output logic                 range_err,
    output logic [7:0]           first_err_idx,
    output chk_state_t           dbg_state
);

    // Handshake: the upstream holds rready with a value on `in`; the checker
    // takes it on a RUN-state edge and answers with a one-cycle read pulse.
    // A transfer is complete only when read was high at a clock edge.

    localparam logic [AW-1:0] DEPTH_L = AW'(DEPTH);

    chk_state_t            state;
    logic                  need_load;
    logic [AW-1:0]         len_q;
    logic [AW-1:0]         clamped_len;
    logic [AW-1:0]         cur_len;
    logic signed [DW-1:0]  exp_val;
    logic                  accept;
    logic                  match;

    // exp_len is taken on the first edge after reset or clear; until then it
    // is used directly so the very first value can be accepted at full rate.
    always_comb begin
        clamped_len = (exp_len > DEPTH_L) ? DEPTH_L : exp_len;
        cur_len     = need_load ? clamped_len : len_q;
        exp_val     = '0;
        if (count < 8'(DEPTH)) begin
            exp_val = expected[count[AW-1:0]];
        end
        match  = (in == exp_val);
        accept = (state == RUN) && rready && !read && !clear
                 && (count < 8'(cur_len));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            need_load     <= 1'b1;
            len_q         <= '0;
            read          <= 1'b0;
            count         <= '0;
            correct       <= '0;
            last_value    <= '0;
            err           <= 1'b0;
            range_err     <= 1'b0;
            first_err_idx <= 8'hFF;
        end else if (clear) begin
            state         <= RUN;
            need_load     <= 1'b1;
            len_q         <= '0;
            read          <= 1'b0;
            count         <= '0;
            correct       <= '0;
            last_value    <= '0;
            err           <= 1'b0;
            range_err     <= 1'b0;
            first_err_idx <= 8'hFF;
        end else begin
            read <= accept;
            if (need_load) begin
                len_q     <= clamped_len;
                need_load <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (need_load && (clamped_len == '0)) begin
                        state <= DONE;
                    end else if (accept) begin
                        state      <= ACK;
                        last_value <= in;
                        count      <= count + 8'd1;
                        if (match) begin
                            correct <= correct + 8'd1;
                        end else begin
                            err <= 1'b1;
                            if (!err) first_err_idx <= count;
                        end
                        if (!in_range(in)) range_err <= 1'b1;
                    end
                end
                // count already holds the post-accept value here
                ACK:     state <= (count == 8'(len_q)) ? DONE : RUN;
                DONE:    state <= DONE;
                default: state <= RUN;
            endcase
        end
    end

    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_stream_checker.sv
// Bench for stream_checker: directed handshake sequences plus a vector table,
// with accepted values scored through an expected queue.
module tb_stream_checker;
    import tis_pkg::*;

    localparam int DW    = 11;
    localparam int DEPTH = 39;
    localparam int AW    = $clog2(DEPTH + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clear = 1'b0;
    logic [AW-1:0]        exp_len = '0;
    logic signed [DW-1:0] expected [DEPTH];
    logic                 rready = 1'b0;
    logic signed [DW-1:0] din = '0;
    logic                 read;
    logic [7:0]           count;
    logic [7:0]           correct;
    logic signed [DW-1:0] last_value;
    logic                 done;
    logic                 err;
    logic                 range_err;
    logic [7:0]           first_err_idx;
    chk_state_t           dbg_state;

    stream_checker #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .exp_len(exp_len),
        .expected(expected), .rready(rready), .in(din), .read(read),
        .count(count), .correct(correct), .last_value(last_value),
        .done(done), .err(err), .range_err(range_err),
        .first_err_idx(first_err_idx), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rd_cyc [$];
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic signed [DW-1:0] din;
        logic signed [DW-1:0] exp;
        bit                   match;
        bit                   rng;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, req);
        end
    endtask

    // scoreboard: every read pulse must correspond to the oldest driven value
    logic prev_read = 1'b0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (read === 1'b1) begin
            rd_cyc.push_back(cyc);
            check("read_not_back_to_back", {31'b0, prev_read}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_read", 32'd1, 32'd0);
            end else begin
                check("last_value", 32'(last_value), 32'(signed'(exp_q.pop_front())));
            end
        end
        prev_read = read;
    end

    task automatic send(input logic signed [DW-1:0] v);
        bit ok = 1'b0;
        din = v;
        rready = 1'b1;
        exp_q.push_back(v);
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (read === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            check("send_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic do_clear(input logic [AW-1:0] len);
        @(posedge clk);
        #1;
        exp_len = len;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clear_count", 32'(count), 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncorr;
        bit  e_err;
        bit  e_rng;
        logic [7:0] e_fe;

        for (int i = 0; i < DEPTH; i++) expected[i] = '0;

        // reset state
        exp_len = 3;
        expected[0] = 11'sd5;
        expected[1] = -11'sd7;
        expected[2] = 11'sd0;
        #12;
        check("rst_read", {31'b0, read}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_correct", 32'(correct), 32'd0);
        check("rst_last", 32'(last_value), 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_range_err", {31'b0, range_err}, 32'd0);
        check("rst_first_err", 32'(first_err_idx), 32'hFF);
        @(negedge clk);
        rst = 1'b1;

        // full-rate stream of three matching values
        @(posedge clk);
        #1;
        rd_cyc.delete();
        send(11'sd5);
        send(-11'sd7);
        send(11'sd0);
        rready = 1'b0;
        wait_cycles(2);
        check("t1_reads", 32'(rd_cyc.size()), 32'd3);
        if (rd_cyc.size() == 3) begin
            check("t1_gap0", 32'(rd_cyc[1] - rd_cyc[0]), 32'd2);
            check("t1_gap1", 32'(rd_cyc[2] - rd_cyc[1]), 32'd2);
        end
        check("t1_count", 32'(count), 32'd3);
        check("t1_correct", 32'(correct), 32'd3);
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_err", {31'b0, err}, 32'd0);
        check("t1_first_err", 32'(first_err_idx), 32'hFF);

        // vector table: mismatches, range limits and the -1024 corner
        tbl[0] = '{11'sd1,    11'sd1,    1'b1, 1'b0};
        tbl[1] = '{11'sd9,    11'sd2,    1'b0, 1'b0};
        tbl[2] = '{11'sd3,    11'sd3,    1'b1, 1'b0};
        tbl[3] = '{11'sd8,    11'sd4,    1'b0, 1'b0};
        tbl[4] = '{11'sd999,  11'sd999,  1'b1, 1'b0};
        tbl[5] = '{-11'sd999, -11'sd999, 1'b1, 1'b0};
        tbl[6] = '{11'sd1000, 11'sd1000, 1'b1, 1'b1};
        tbl[7] = '{11'sh400,  11'sh400,  1'b1, 1'b1};
        tbl[8] = '{-11'sd1000, 11'sd5,   1'b0, 1'b1};
        for (int i = 0; i < 9; i++) expected[i] = tbl[i].exp;
        do_clear(6'd9);
        check("t2_first_err_clr", 32'(first_err_idx), 32'hFF);
        ncorr = 0;
        e_err = 1'b0;
        e_rng = 1'b0;
        e_fe  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].din);
            if (tbl[i].match) ncorr++;
            else begin
                if (!e_err) e_fe = 8'(i);
                e_err = 1'b1;
            end
            e_rng = e_rng | tbl[i].rng;
            check($sformatf("t2_count_%0d", i), 32'(count), 32'(i + 1));
            check($sformatf("t2_correct_%0d", i), 32'(correct), 32'(ncorr));
            check($sformatf("t2_err_%0d", i), {31'b0, err}, {31'b0, e_err});
            check($sformatf("t2_first_err_%0d", i), 32'(first_err_idx), 32'(e_fe));
            check($sformatf("t2_range_err_%0d", i), {31'b0, range_err}, {31'b0, e_rng});
        end
        rready = 1'b0;
        wait_cycles(2);
        check("t2_done", {31'b0, done}, 32'd1);
        check("t2_correct_final", 32'(correct), 32'd6);

        // after done, a held request is ignored
        expected[0] = 11'sd42;
        expected[1] = 11'sd42;
        do_clear(6'd2);
        send(11'sd42);
        send(11'sd42);
        wait_cycles(2);
        check("t3_done", {31'b0, done}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t3_read_idle", {31'b0, read}, 32'd0);
            check("t3_count_hold", 32'(count), 32'd2);
        end
        rready = 1'b0;

        // clear in the same cycle rready rises
        expected[0] = 11'sd17;
        @(posedge clk);
        #1;
        exp_len = 6'd1;
        clear = 1'b1;
        din = 11'sd17;
        rready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_read_on_clear", {31'b0, read}, 32'd0);
        check("t4_count_on_clear", 32'(count), 32'd0);
        clear = 1'b0;
        exp_q.push_back(11'sd17);
        @(posedge clk);
        #1;
        check("t4_read_after", {31'b0, read}, 32'd1);
        check("t4_count_after", 32'(count), 32'd1);
        rready = 1'b0;
        wait_cycles(2);

        // asynchronous reset while read is high
        expected[0] = 11'sd3;
        expected[1] = 11'sd4;
        do_clear(6'd2);
        send(11'sd3);
        check("t5_read_high", {31'b0, read}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t5_read", {31'b0, read}, 32'd0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_correct", 32'(correct), 32'd0);
        check("t5_last", 32'(last_value), 32'd0);
        check("t5_err", {31'b0, err}, 32'd0);
        check("t5_range_err", {31'b0, range_err}, 32'd0);
        check("t5_first_err", 32'(first_err_idx), 32'hFF);
        check("t5_done", {31'b0, done}, 32'd0);
        rready = 1'b0;
        exp_len = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_done_len0", {31'b0, done}, 32'd1);
        check("t5_state_len0", 32'(dbg_state), 32'(DONE));

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
